// File: rtl/ddr_txn_issue.sv
// ddr_txn_issue
// Host-side transaction queue and command issuer placed in front of the DDR
// controller. Requests are held in a DEPTH-entry FIFO. The head entry is
// presented on the controller-facing signals with a one-cycle act_cmd strobe.
// The entry is popped when the controller acknowledges by showing dev_busy
// high while the command is outstanding. If no acknowledge arrives within
// ACK_TIMEOUT cycles, the same command is strobed again and retry_cnt counts up.
//
// Ports
//   clock      in   sole clock, rising edge
//   reset      in   asynchronous active-high reset, clears all state
//   req_valid  in   host request present
//   req_ready  out  FIFO can accept (not full, taken from the current count)
//   req_rw     in   2'b01 read, 2'b10 write; other codes are accepted and dropped
//   req_addr   in   request address
//   req_data   in   write data (ignored for reads)
//   next_cmd   in   controller ready for a new command (looked at only in IDLE)
//   dev_busy   in   controller busy; counts as acknowledge while a command is out
//   act_cmd    out  one-cycle command strobe
//   dev_rw     out  head-entry rw, held while a command is outstanding, else 0
//   cmd_addr   out  head-entry address, same holding rule
//   cmd_data   out  head-entry data, same holding rule
//   count      out  FIFO occupancy
//   retry_cnt  out  saturating count of timeout re-issues

module ddr_txn_issue #(
    parameter int DEPTH       = 8,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_rw,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_data,
    input  logic                     next_cmd,
    input  logic                     dev_busy,
    output logic                     act_cmd,
    output logic [1:0]               dev_rw,
    output logic [ADDR_W-1:0]        cmd_addr,
    output logic [DATA_W-1:0]        cmd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               retry_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(ACK_TIMEOUT);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1'b1);
    localparam logic [TMR_W-1:0] TMR_ZERO   = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1'b1);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_ISSUE    = 2'b01,
        ST_WAIT_ACK = 2'b10
    } state_t;

    // FIFO storage and bookkeeping
    logic [1:0]        rw_mem_r   [DEPTH];
    logic [ADDR_W-1:0] addr_mem_r [DEPTH];
    logic [DATA_W-1:0] data_mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

    // Issue control
    state_t            state_r;
    state_t            state_next_s;
    logic [TMR_W-1:0]  timer_r;
    logic [7:0]        retry_r;

    // Registered controller-facing outputs
    logic              act_cmd_r;
    logic [1:0]        dev_rw_r;
    logic [ADDR_W-1:0] cmd_addr_r;
    logic [DATA_W-1:0] cmd_data_r;

    // Per-cycle decisions
    logic              full_s;
    logic              rw_legal_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;
    logic              timer_clr_s;
    logic              timer_inc_s;
    logic              retry_inc_s;

    // req_ready depends only on the pre-edge count, so a full FIFO stays
    // blocked even on an edge where the head is popped.
    assign full_s     = (count_r == FULL_COUNT);
    assign rw_legal_s = (req_rw == 2'b01) || (req_rw == 2'b10);
    assign accept_s   = req_valid && !full_s;
    // Illegal rw codes complete the handshake but are never stored.
    assign push_s     = accept_s && rw_legal_s;

    assign req_ready  = !full_s;
    assign act_cmd    = act_cmd_r;
    assign dev_rw     = dev_rw_r;
    assign cmd_addr   = cmd_addr_r;
    assign cmd_data   = cmd_data_r;
    assign count      = count_r;
    assign retry_cnt  = retry_r;

    // Next-state and control decode for the issue FSM.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        timer_clr_s  = 1'b0;
        timer_inc_s  = 1'b0;
        retry_inc_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if ((count_r != CNT_ZERO) && next_cmd && !dev_busy) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // dev_busy already high during the strobe counts as an immediate ack.
                if (dev_busy) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    timer_clr_s  = 1'b1;
                    state_next_s = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (dev_busy) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_IDLE;
                end else if (timer_r == TMR_LAST) begin
                    retry_inc_s  = 1'b1;
                    state_next_s = ST_ISSUE;
                end else begin
                    timer_inc_s  = 1'b1;
                    state_next_s = ST_WAIT_ACK;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Acknowledge timer: cleared on each strobe, advanced while waiting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer_r <= TMR_ZERO;
        end else if (timer_clr_s) begin
            timer_r <= TMR_ZERO;
        end else if (timer_inc_s) begin
            timer_r <= timer_r + TMR_ONE;
        end else begin
            timer_r <= timer_r;
        end
    end

    // Saturating count of timeout re-issues.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retry_r <= 8'd0;
        end else if (retry_inc_s && (retry_r != 8'hFF)) begin
            retry_r <= retry_r + 8'd1;
        end else begin
            retry_r <= retry_r;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage write port; contents need no reset since count gates use.
    always_ff @(posedge clock) begin
        if (push_s) begin
            rw_mem_r[wr_ptr_r]   <= req_rw;
            addr_mem_r[wr_ptr_r] <= req_addr;
            data_mem_r[wr_ptr_r] <= req_data;
        end
    end

    // Controller-facing outputs, registered from the next state.
    // A non-IDLE next state never coincides with a pop, and a push cannot
    // land in the head slot while the FIFO is non-empty, so the head read
    // here is the entry that is outstanding in the next cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            act_cmd_r  <= 1'b0;
            dev_rw_r   <= 2'b00;
            cmd_addr_r <= {ADDR_W{1'b0}};
            cmd_data_r <= {DATA_W{1'b0}};
        end else begin
            act_cmd_r <= (state_next_s == ST_ISSUE);
            if (state_next_s != ST_IDLE) begin
                dev_rw_r   <= rw_mem_r[rd_ptr_r];
                cmd_addr_r <= addr_mem_r[rd_ptr_r];
                cmd_data_r <= data_mem_r[rd_ptr_r];
            end else begin
                dev_rw_r   <= 2'b00;
                cmd_addr_r <= {ADDR_W{1'b0}};
                cmd_data_r <= {DATA_W{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_ddr_txn_issue.sv
// Directed self-checking bench for ddr_txn_issue (DEPTH=8, ACK_TIMEOUT=16).
// Inputs are driven 1 time unit after a rising edge; outputs are sampled at
// that same point, away from the active edge.

module tb_ddr_txn_issue;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_rw;
    logic [31:0] req_addr;
    logic [63:0] req_data;
    logic        next_cmd;
    logic        dev_busy;
    logic        act_cmd;
    logic [1:0]  dev_rw;
    logic [31:0] cmd_addr;
    logic [63:0] cmd_data;
    logic [3:0]  count;
    logic [7:0]  retry_cnt;

    int n_checks;
    int n_fail;

    ddr_txn_issue #(
        .DEPTH(8), .ADDR_W(32), .DATA_W(64), .ACK_TIMEOUT(16)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_data(req_data),
        .next_cmd(next_cmd), .dev_busy(dev_busy),
        .act_cmd(act_cmd), .dev_rw(dev_rw), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .count(count), .retry_cnt(retry_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_rw = 2'b00; req_addr = 32'h0;
        req_data = 64'h0; next_cmd = 1'b0; dev_busy = 1'b0;
        tick(); tick();
        n_checks++; if (act_cmd !== 1'b0) begin n_fail++; $display("FAIL reset_act_cmd got %b exp 0", act_cmd); end
        n_checks++; if (dev_rw !== 2'b00) begin n_fail++; $display("FAIL reset_dev_rw got %b exp 00", dev_rw); end
        n_checks++; if (cmd_addr !== 32'h0) begin n_fail++; $display("FAIL reset_cmd_addr got %h exp 0", cmd_addr); end
        n_checks++; if (cmd_data !== 64'h0) begin n_fail++; $display("FAIL reset_cmd_data got %h exp 0", cmd_data); end
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
        n_checks++; if (retry_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_retry got %0d exp 0", retry_cnt); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        next_cmd = 1'b1; dev_busy = 1'b0;
        req_valid = 1'b1; req_rw = 2'b10; req_addr = 32'h0000_0100; req_data = 64'h0000_0000_0000_A5A5;
        tick();  // push edge k
        req_valid = 1'b0; req_rw = 2'b00;
        n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL single_count_after_push got %0d exp 1", count); end
        n_checks++; if (act_cmd !== 1'b0) begin n_fail++; $display("FAIL single_act_early got %b exp 0", act_cmd); end
        tick();  // edge k+1: strobe cycle
        n_checks++; if (act_cmd !== 1'b1) begin n_fail++; $display("FAIL single_act_strobe got %b exp 1", act_cmd); end
        n_checks++; if (dev_rw !== 2'b10) begin n_fail++; $display("FAIL single_dev_rw got %b exp 10", dev_rw); end
        n_checks++; if (cmd_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL single_cmd_addr got %h exp 00000100", cmd_addr); end
        n_checks++; if (cmd_data !== 64'h0000_0000_0000_A5A5) begin n_fail++; $display("FAIL single_cmd_data got %h exp a5a5", cmd_data); end
        dev_busy = 1'b1;
        tick();  // edge k+2: acknowledge and pop
        dev_busy = 1'b0;
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL single_count_after_pop got %0d exp 0", count); end
        n_checks++; if (act_cmd !== 1'b0) begin n_fail++; $display("FAIL single_act_after_ack got %b exp 0", act_cmd); end
        n_checks++; if (dev_rw !== 2'b00) begin n_fail++; $display("FAIL single_idle_dev_rw got %b exp 00", dev_rw); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (act_cmd !== 1'b0) begin n_fail++; $display("FAIL single_no_repeat got %b exp 0 cycle %0d", act_cmd, i); end
        end
        n_checks++; if (retry_cnt !== 8'd0) begin n_fail++; $display("FAIL single_retry got %0d exp 0", retry_cnt); end
    endtask

    task automatic test_fill_and_order();
        next_cmd = 1'b0; dev_busy = 1'b0;
        for (int i = 0; i < 9; i++) begin
            req_valid = 1'b1;
            req_rw    = (i % 2 == 0) ? 2'b10 : 2'b01;
            req_addr  = 32'h0000_0200 + 32'(i * 4);
            req_data  = 64'(i + 16);
            n_checks++;
            if (req_ready !== ((i < 8) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL fill_req_ready push %0d got %b exp %b", i, req_ready, (i < 8));
            end
            tick();
        end
        req_valid = 1'b0; req_rw = 2'b00;
        n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL fill_count got %0d exp 8", count); end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready got %b exp 0", req_ready); end
        next_cmd = 1'b1;
        for (int i = 0; i < 8; i++) begin
            int waited;
            waited = 0;
            while (act_cmd !== 1'b1 && waited < 6) begin tick(); waited++; end
            n_checks++; if (act_cmd !== 1'b1) begin n_fail++; $display("FAIL fill_issue_wait entry %0d got no strobe", i); end
            n_checks++;
            if (cmd_addr !== 32'h0000_0200 + 32'(i * 4)) begin
                n_fail++; $display("FAIL fill_order_addr entry %0d got %h exp %h", i, cmd_addr, 32'h0000_0200 + 32'(i * 4));
            end
            n_checks++;
            if (dev_rw !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL fill_order_rw entry %0d got %b", i, dev_rw);
            end
            dev_busy = 1'b1;
            tick();
            dev_busy = 1'b0;
        end
        tick(); tick(); tick();
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL fill_ninth_stored count got %0d exp 0", count); end
        n_checks++; if (act_cmd !== 1'b0) begin n_fail++; $display("FAIL fill_extra_strobe got %b exp 0", act_cmd); end
    endtask

    task automatic test_timeout();
        next_cmd = 1'b1; dev_busy = 1'b0;
        req_valid = 1'b1; req_rw = 2'b01; req_addr = 32'h0000_0300; req_data = 64'h0;
        tick();
        req_valid = 1'b0; req_rw = 2'b00;
        tick();
        n_checks++; if (act_cmd !== 1'b1) begin n_fail++; $display("FAIL timeout_first_strobe got %b exp 1", act_cmd); end
        for (int r = 1; r <= 2; r++) begin
            for (int c = 1; c <= 17; c++) begin
                tick();
                if (c < 17) begin
                    n_checks++; if (act_cmd !== 1'b0) begin n_fail++; $display("FAIL timeout_quiet round %0d cycle %0d got %b exp 0", r, c, act_cmd); end
                    n_checks++; if (cmd_addr !== 32'h0000_0300) begin n_fail++; $display("FAIL timeout_hold_addr round %0d cycle %0d got %h exp 00000300", r, c, cmd_addr); end
                end else begin
                    n_checks++; if (act_cmd !== 1'b1) begin n_fail++; $display("FAIL timeout_reissue round %0d got %b exp 1", r, act_cmd); end
                    n_checks++; if (retry_cnt !== 8'(r)) begin n_fail++; $display("FAIL timeout_retry round %0d got %0d exp %0d", r, retry_cnt, r); end
                    n_checks++; if (dev_rw !== 2'b01) begin n_fail++; $display("FAIL timeout_hold_rw round %0d got %b exp 01", r, dev_rw); end
                end
            end
        end
        dev_busy = 1'b1;
        tick();
        dev_busy = 1'b0;
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL timeout_pop count got %0d exp 0", count); end
        repeat (20) tick();
        n_checks++; if (retry_cnt !== 8'd2) begin n_fail++; $display("FAIL timeout_retry_frozen got %0d exp 2", retry_cnt); end
        n_checks++; if (act_cmd !== 1'b0) begin n_fail++; $display("FAIL timeout_after_ack got %b exp 0", act_cmd); end
    endtask

    task automatic test_illegal_rw();
        next_cmd = 1'b1; dev_busy = 1'b0;
        req_valid = 1'b1; req_rw = 2'b11; req_addr = 32'h0000_0400;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_ready got %b exp 1", req_ready); end
        tick();
        req_rw = 2'b00;
        tick();
        req_valid = 1'b0;
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL illegal_count got %0d exp 0", count); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (act_cmd !== 1'b0) begin n_fail++; $display("FAIL illegal_no_strobe cycle %0d got %b exp 0", i, act_cmd); end
        end
    endtask

    task automatic test_reset_mid();
        next_cmd = 1'b0; dev_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_rw = 2'b10; req_addr = 32'h0000_0500 + 32'(i); req_data = 64'hFFFF_0000_0000_0000 + 64'(i);
            tick();
        end
        req_valid = 1'b0; req_rw = 2'b00;
        next_cmd = 1'b1;
        tick();  // strobe
        n_checks++; if (act_cmd !== 1'b1) begin n_fail++; $display("FAIL midrst_strobe got %b exp 1", act_cmd); end
        tick(); tick();  // now waiting for acknowledge
        n_checks++; if (count !== 4'd3) begin n_fail++; $display("FAIL midrst_count_before got %0d exp 3", count); end
        reset = 1'b1;
        #1;
        n_checks++; if (act_cmd !== 1'b0) begin n_fail++; $display("FAIL midrst_act got %b exp 0", act_cmd); end
        n_checks++; if (dev_rw !== 2'b00) begin n_fail++; $display("FAIL midrst_dev_rw got %b exp 00", dev_rw); end
        n_checks++; if (cmd_addr !== 32'h0) begin n_fail++; $display("FAIL midrst_addr got %h exp 0", cmd_addr); end
        n_checks++; if (cmd_data !== 64'h0) begin n_fail++; $display("FAIL midrst_data got %h exp 0", cmd_data); end
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL midrst_count got %0d exp 0", count); end
        n_checks++; if (retry_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst_retry got %0d exp 0", retry_cnt); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b exp 1", req_ready); end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (act_cmd !== 1'b0) begin n_fail++; $display("FAIL midrst_after_release cycle %0d got %b exp 0", i, act_cmd); end
        end
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL midrst_count_after got %0d exp 0", count); end
    endtask

    task automatic test_stream();
        int push_idx;
        int pop_idx;
        int cyc;
        logic pushing;
        push_idx = 0; pop_idx = 0; cyc = 0;
        next_cmd = 1'b1; dev_busy = 1'b0;
        while (pop_idx < 20 && cyc < 400) begin
            if (act_cmd === 1'b1) begin
                n_checks++;
                if (cmd_addr !== 32'h0000_1000 + 32'(pop_idx * 16)) begin
                    n_fail++; $display("FAIL stream_addr entry %0d got %h exp %h", pop_idx, cmd_addr, 32'h0000_1000 + 32'(pop_idx * 16));
                end
                n_checks++;
                if (dev_rw !== ((pop_idx % 2 == 0) ? 2'b10 : 2'b01)) begin
                    n_fail++; $display("FAIL stream_rw entry %0d got %b", pop_idx, dev_rw);
                end
                pop_idx++;
                dev_busy = 1'b1;
            end else begin
                dev_busy = 1'b0;
            end
            n_checks++; if (count > 4'd8) begin n_fail++; $display("FAIL stream_overflow count got %0d exp at most 8", count); end
            if (push_idx < 20) begin
                req_valid = 1'b1;
                req_rw    = (push_idx % 2 == 0) ? 2'b10 : 2'b01;
                req_addr  = 32'h0000_1000 + 32'(push_idx * 16);
                req_data  = 64'(push_idx);
                pushing   = req_ready;
            end else begin
                req_valid = 1'b0;
                req_rw    = 2'b00;
                pushing   = 1'b0;
            end
            tick();
            if (pushing) push_idx++;
            cyc++;
        end
        req_valid = 1'b0; dev_busy = 1'b0;
        n_checks++; if (pop_idx != 20) begin n_fail++; $display("FAIL stream_timeout issued %0d exp 20", pop_idx); end
        tick();
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL stream_final_count got %0d exp 0", count); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_write();
        test_fill_and_order();
        test_timeout();
        test_illegal_rw();
        test_reset_mid();
        test_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
